// File: rtl/elevator_dispatcher.sv
// Single-car elevator dispatcher: pops one request at a time from an external
// FIFO, travels floor by floor to it, holds the door open, then returns to IDLE.
`timescale 1ns/1ps
module elevator_dispatcher #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6,
  parameter int TOP_FLOOR     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_floor,
  input  logic       req_empty,
  input  logic       stop,
  output logic       shift,
  output logic [3:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       busy
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UP,
    S_DOWN,
    S_DOOR
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    floor_q, floor_d;
  logic [3:0]    target_q, target_d;
  logic [TW-1:0] trav_cnt_q, trav_cnt_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      floor_q    <= 4'd0;
      target_q   <= 4'd0;
      trav_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      target_q   <= target_d;
      trav_cnt_q <= trav_cnt_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    target_d   = target_q;
    trav_cnt_d = trav_cnt_q;
    door_cnt_d = door_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!req_empty) begin
          target_d = req_floor;
          state_d  = S_FETCH;
        end
      end
      // FETCH always completes in one cycle so the pop strobe is never stretched by stop.
      S_FETCH: begin
        if (int'(target_q) > TOP_FLOOR) state_d = S_IDLE;
        else if (target_q > floor_q)    state_d = S_UP;
        else if (target_q < floor_q)    state_d = S_DOWN;
        else                            state_d = S_DOOR;
      end
      S_UP, S_DOWN: begin
        if (!stop) begin
          if (trav_cnt_q == TRAVEL_LAST) begin
            trav_cnt_d = '0;
            floor_d    = (state_q == S_UP) ? floor_q + 4'd1 : floor_q - 4'd1;
            if (floor_d == target_q) state_d = S_DOOR;
          end else begin
            trav_cnt_d = trav_cnt_q + TW'(1);
          end
        end
      end
      S_DOOR: begin
        if (!stop) begin
          if (door_cnt_q == DOOR_LAST) begin
            door_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure state decodes, so async reset clears them immediately.
  assign shift       = (state_q == S_FETCH);
  assign moving_up   = (state_q == S_UP);
  assign moving_down = (state_q == S_DOWN);
  assign door_open   = (state_q == S_DOOR);
  assign busy        = (state_q != S_IDLE);
  assign floor       = floor_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Self-checking bench for elevator_dispatcher: directed transaction table,
// hand-written corner sequences and a randomized run against a plan-queue model.
`timescale 1ns/1ps
module tb_elevator_dispatcher;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int TOP    = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic       req_empty = 1'b1;
  logic       stop = 1'b0;
  logic       shift, moving_up, moving_down, door_open, busy;
  logic [3:0] floor;
  logic       shift9, moving_up9, moving_down9, door_open9, busy9;
  logic [3:0] floor9;

  elevator_dispatcher #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .TOP_FLOOR(TOP)) dut (
    .clk(clk), .rst_n(rst_n), .req_floor(req_floor), .req_empty(req_empty), .stop(stop),
    .shift(shift), .floor(floor), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .busy(busy));

  // Second car with a lower top floor, used only to exercise request discard.
  elevator_dispatcher #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .TOP_FLOOR(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .req_floor(req_floor), .req_empty(req_empty), .stop(stop),
    .shift(shift9), .floor(floor9), .moving_up(moving_up9), .moving_down(moving_down9),
    .door_open(door_open9), .busy(busy9));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       shift;
    logic       up;
    logic       down;
    logic       door;
    logic       busy;
    logic [3:0] floor;
  } obs_t;

  typedef struct {
    int req; int stop_at; int stop_len;
    int e_up; int e_down; int e_door; int e_arrive; int e_busy; int e_floor;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t cur;
  obs_t plan[$];
  int   mf;
  int   rq[$];
  int   doors[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs();
    obs_t o;
    o.shift = shift; o.up = moving_up; o.down = moving_down;
    o.door = door_open; o.busy = busy; o.floor = floor;
    return o;
  endfunction

  function automatic obs_t mk(logic s, logic u, logic d, logic o, logic b, int f);
    obs_t r;
    r.shift = s; r.up = u; r.down = d; r.door = o; r.busy = b; r.floor = 4'(f);
    return r;
  endfunction

  // Reference: each accepted request expands into its full per-cycle output plan.
  task automatic model_step();
    int t;
    int f;
    if (cur.busy && stop && !cur.shift) begin
      // frozen by emergency hold
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else if (cur.busy) begin
      cur = mk(0, 0, 0, 0, 0, mf);
    end else if (!req_empty) begin
      t = int'(req_floor);
      plan.push_back(mk(1, 0, 0, 0, 1, mf));
      if (t <= TOP) begin
        f = mf;
        while (f != t) begin
          for (int c = 0; c < TRAVEL; c++) plan.push_back(mk(0, t > f, t < f, 0, 1, f));
          f += (t > f) ? 1 : -1;
        end
        for (int c = 0; c < DOOR; c++) plan.push_back(mk(0, 0, 0, 1, 1, t));
        mf = t;
      end
      cur = plan.pop_front();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_empty = 1'b1; stop = 1'b0; req_floor = 4'd0;
    #1;
    check("reset_outputs", int'(obs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[6];
  int   n_sh, n_up, n_dn, n_dr, n_bz, arr, acc, acc2, acc3;
  bit   done, prev_door;

  initial begin
    tbl[0] = '{2,  0,  0, 8,  0,  3, 9,  12, 2};
    tbl[1] = '{2,  0,  0, 0,  0,  3, 1,  4,  2};
    tbl[2] = '{0,  3,  5, 0,  13, 3, 14, 17, 0};
    tbl[3] = '{15, 0,  0, 60, 0,  3, 61, 64, 15};
    tbl[4] = '{14, 0,  0, 0,  4,  3, 5,  8,  14};
    tbl[5] = '{0,  10, 2, 0,  58, 3, 59, 62, 0};

    // Idle with an empty queue: nothing may happen.
    do_reset();
    acc = 0; acc2 = 0; acc3 = 0;
    for (int c = 0; c < 20; c++) begin
      acc += int'(shift); acc2 += int'(busy); acc3 += (floor != 4'd0) ? 1 : 0;
      @(negedge clk);
    end
    check("idle_shift_count", acc, 0);
    check("idle_busy_count", acc2, 0);
    check("idle_floor_nonzero", acc3, 0);

    // Out-of-range target is popped then discarded by the TOP_FLOOR=9 car.
    req_floor = 4'd12; req_empty = 1'b0;
    @(negedge clk);
    req_empty = 1'b1;
    check("discard_fetch_shift", int'(shift9), 1);
    @(negedge clk);
    check("discard_busy_after", int'(busy9), 0);
    check("discard_no_move", int'({moving_up9, moving_down9, door_open9}), 0);
    check("discard_floor", int'(floor9), 0);
    done = 0;
    for (int c = 0; c < 120 && !done; c++) begin
      if (!busy) done = 1; else @(negedge clk);
    end
    check("discard_main_idle_timeout", int'(done), 1);

    // Directed transaction table.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      n_sh = 0; n_up = 0; n_dn = 0; n_dr = 0; n_bz = 0; arr = -1; done = 0;
      req_floor = 4'(tbl[r].req); req_empty = 1'b0;
      @(negedge clk);
      req_empty = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
        if (busy) begin
          n_bz++; n_sh += int'(shift); n_up += int'(moving_up);
          n_dn += int'(moving_down); n_dr += int'(door_open);
          if (door_open && arr < 0) arr = c;
        end else begin
          done = 1;
        end
        if (!done) begin
          stop = (tbl[r].stop_len > 0) && (c >= tbl[r].stop_at) && (c < tbl[r].stop_at + tbl[r].stop_len);
          @(negedge clk);
        end
      end
      stop = 1'b0;
      check($sformatf("tbl%0d_timeout", r), int'(done), 1);
      check($sformatf("tbl%0d_shift", r), n_sh, 1);
      check($sformatf("tbl%0d_up", r), n_up, tbl[r].e_up);
      check($sformatf("tbl%0d_down", r), n_dn, tbl[r].e_down);
      check($sformatf("tbl%0d_door", r), n_dr, tbl[r].e_door);
      check($sformatf("tbl%0d_arrive", r), arr, tbl[r].e_arrive);
      check($sformatf("tbl%0d_busy", r), n_bz, tbl[r].e_busy);
      check($sformatf("tbl%0d_floor", r), int'(floor), tbl[r].e_floor);
    end

    // Two queued requests served back to back from a FIFO model.
    rq = {3, 1}; doors.delete(); n_sh = 0; prev_door = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (shift) begin n_sh++; void'(rq.pop_front()); end
      if (door_open && !prev_door) doors.push_back(int'(floor));
      prev_door = door_open;
      if (rq.size() == 0 && !busy) done = 1;
      req_empty = (rq.size() == 0);
      req_floor = (rq.size() > 0) ? 4'(rq[0]) : 4'd0;
      if (!done) @(negedge clk);
    end
    req_empty = 1'b1;
    check("queue_timeout", int'(done), 1);
    check("queue_shifts", n_sh, 2);
    check("queue_door_stops", doors.size(), 2);
    if (doors.size() == 2) begin
      check("queue_first_stop", doors[0], 3);
      check("queue_second_stop", doors[1], 1);
    end
    check("queue_final_floor", int'(floor), 1);

    // Asynchronous reset while travelling between floors 1 and 2.
    do_reset();
    req_floor = 4'd2; req_empty = 1'b0;
    @(negedge clk);
    req_empty = 1'b1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (floor == 4'd1 && moving_up) done = 1; else @(negedge clk);
    end
    check("midtravel_reach_timeout", int'(done), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midtravel_async_reset", int'(obs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0; acc2 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc += int'(shift); acc2 += int'(busy) + int'(floor);
    end
    check("post_reset_no_shift", acc, 0);
    check("post_reset_idle_floor0", acc2, 0);
    req_floor = 4'd0; req_empty = 1'b0;
    @(negedge clk);
    req_empty = 1'b1;
    check("post_reset_new_shift", int'(shift), 1);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    check("post_reset_idle_timeout", int'(done), 1);

    // Randomized run against the plan-queue model.
    do_reset();
    cur = mk(0, 0, 0, 0, 0, 0); plan.delete(); mf = 0;
    for (int c = 0; c < 2500; c++) begin
      check($sformatf("random_cycle%0d", c), int'(obs()), int'(cur));
      req_empty = ($urandom_range(0, 99) >= 35);
      req_floor = 4'($urandom_range(0, 15));
      stop      = ($urandom_range(0, 99) < 15);
      model_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
